// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update sequencer.
// Holds the default table index width, the 2-bit counter encodings, the
// controller state enum and the queued-update entry layout.
package bp_pkg;

  localparam int BP_INDEX_SIZE = 8;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Invalidated entries start out weakly not-taken.
  localparam logic [1:0] CTR_SWEEP_INIT = CTR_WNT;

  typedef enum logic {SWEEP, RUN} bpState_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } updEntry_t;

  // Saturating step of a 2-bit counter toward the resolved direction.
  function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      case (ctr)
        CTR_SNT: res = CTR_WNT;
        CTR_WNT: res = CTR_WT;
        CTR_WT:  res = CTR_ST;
        default: res = CTR_ST;
      endcase
    end else begin
      case (ctr)
        CTR_ST:  res = CTR_WT;
        CTR_WT:  res = CTR_WNT;
        CTR_WNT: res = CTR_SNT;
        default: res = CTR_SNT;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO of pending predictor updates.
// A push is accepted when there is room or when the same cycle pops, so a
// full queue that is draining never loses an entry. The head is always
// visible combinationally; there is no bypass from push to head.
import bp_pkg::*;

module bp_upd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  updEntry_t pushData,
  output updEntry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  updEntry_t     mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          pushOk;
  logic          popOk;

  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (popOk)  rdPtr <= rdPtr + PTR_ONE;
      case ({pushOk, popOk})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor table update sequencer.
// Sweeps every table entry invalid after reset and on a flush request, then
// drains queued branch resolutions one per cycle as counter read-modify-
// writes through the single table write port. The sweep owns the port.
// Optional build macro BP_UPD_STATS_EN: when defined, DropCount counts pushes
// lost to a full queue (saturating at 255); otherwise DropCount is tied to 0.
import bp_pkg::*;

module bp_update_ctrl #(
  parameter int INDEX_SIZE = BP_INDEX_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     BranchResolved,
  input  logic                     BranchTaken,
  input  logic [31:0]              ResolvedBranchPC,
  input  logic [31:0]              ActualBranchTarget,
  input  logic                     FlushReq,
  output logic [INDEX_SIZE-1:0]    CtrRdIdx,
  input  logic [1:0]               CtrRdData,
  output logic                     TblWe,
  output logic [INDEX_SIZE-1:0]    TblIdx,
  output logic [31-INDEX_SIZE:0]   TblTag,
  output logic [31:0]              TblTarget,
  output logic [1:0]               TblCounter,
  output logic                     TblValid,
  output logic                     Ready,
  output logic                     QueueFull,
  output logic                     FlushDone,
  output logic [7:0]               DropCount
);

  localparam logic [INDEX_SIZE-1:0] IDX_ONE = INDEX_SIZE'(1);

  bpState_t              state;
  bpState_t              stateNext;
  logic [INDEX_SIZE-1:0] sweepIdx;
  logic [INDEX_SIZE-1:0] sweepIdxNext;
  logic                  flushSweep;
  logic                  flushSweepNext;
  logic                  fifoPop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  updEntry_t             pushEntry;
  updEntry_t             headEntry;

  assign pushEntry = '{pc: ResolvedBranchPC, target: ActualBranchTarget, taken: BranchTaken};
  assign CtrRdIdx  = headEntry.pc[INDEX_SIZE-1:0];
  assign QueueFull = fifoFull;

  bp_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) updFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (BranchResolved),
    .pop      (fifoPop),
    .pushData (pushEntry),
    .head     (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // State register: reset always restarts a non-flush sweep at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SWEEP;
      sweepIdx   <= '0;
      flushSweep <= 1'b0;
    end else begin
      state      <= stateNext;
      sweepIdx   <= sweepIdxNext;
      flushSweep <= flushSweepNext;
    end
  end

  // Next state and write-port drive; outputs are held quiet while reset is high.
  always_comb begin
    stateNext      = state;
    sweepIdxNext   = sweepIdx;
    flushSweepNext = flushSweep;
    fifoPop        = 1'b0;
    TblWe          = 1'b0;
    TblIdx         = '0;
    TblTag         = '0;
    TblTarget      = '0;
    TblCounter     = CTR_SNT;
    TblValid       = 1'b0;
    Ready          = 1'b0;
    FlushDone      = 1'b0;

    case (state)
      SWEEP: begin
        TblWe        = 1'b1;
        TblIdx       = sweepIdx;
        TblCounter   = CTR_SWEEP_INIT;
        sweepIdxNext = sweepIdx + IDX_ONE;
        if (sweepIdx == '1) begin
          stateNext      = RUN;
          FlushDone      = flushSweep;
          flushSweepNext = 1'b0;
        end
      end
      RUN: begin
        Ready = 1'b1;
        if (!fifoEmpty) begin
          fifoPop    = 1'b1;
          TblWe      = 1'b1;
          TblIdx     = headEntry.pc[INDEX_SIZE-1:0];
          TblTag     = headEntry.pc[31:INDEX_SIZE];
          TblTarget  = headEntry.target;
          TblCounter = ctrNext(CtrRdData, headEntry.taken);
          TblValid   = 1'b1;
        end
        if (FlushReq) begin
          stateNext      = SWEEP;
          sweepIdxNext   = '0;
          flushSweepNext = 1'b1;
        end
      end
      default: begin
        stateNext    = SWEEP;
        sweepIdxNext = '0;
      end
    endcase

    if (reset) begin
      fifoPop   = 1'b0;
      TblWe     = 1'b0;
      Ready     = 1'b0;
      FlushDone = 1'b0;
    end
  end

`ifdef BP_UPD_STATS_EN
  logic [7:0] dropCnt;
  logic       dropNow;

  assign dropNow   = BranchResolved && fifoFull && !fifoPop;
  assign DropCount = dropCnt;

  // Count pushes turned away by a full queue, sticking at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      dropCnt <= 8'd0;
    end else if (dropNow && (dropCnt != 8'hFF)) begin
      dropCnt <= dropCnt + 8'd1;
    end
  end
`else
  assign DropCount = 8'd0;
`endif

endmodule
